btn_conditioner: RTL

Front-end input stage for the tic-tac-toe board controller: conditions the five raw push-buttons and drives the game state machine's BtnC/BtnU/BtnD/BtnR/BtnL inputs. Each button gets a 2-FF synchronizer, a debounce filter and press-edge detection. Presses are queued in per-button pending bits, and an arbiter releases at most one single-cycle pulse at a time, with a guaranteed gap so the state machine's QWINCON cycle never drops a press.

---
 rtl/btn_pkg.sv | 30 +++
 rtl/btn_debounce.sv | 55 +++++
 rtl/btn_conditioner.sv | 74 +++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared constants for the button conditioner: button indices, the arbiter's
// service order, and a priority picker used by the top level.
package btn_pkg;

  localparam int BTN_C   = 0;
  localparam int BTN_U   = 1;
  localparam int BTN_D   = 2;
  localparam int BTN_R   = 3;
  localparam int BTN_L   = 4;
  localparam int NUM_BTN = 5;

  // Service order, highest priority first. L deliberately outranks R even
  // though R has the lower bit index.
  localparam int PRIO [NUM_BTN] = '{BTN_C, BTN_U, BTN_D, BTN_L, BTN_R};

  // One-hot of the highest-priority requesting button, or zero if none.
  // Walks from lowest to highest priority so the last hit wins.
  function automatic logic [NUM_BTN-1:0] pick_prio(input logic [NUM_BTN-1:0] req);
    logic [NUM_BTN-1:0] sel;
    sel = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (req[PRIO[i]]) begin
        sel           = '0;
        sel[PRIO[i]]  = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchronizer, debounce counter, stable level and
// a single-cycle rise strobe coincident with the stable 0->1 transition.
module btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic Clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          accept;

  // Two-flop synchronizer for the asynchronous raw level.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  // A new level is accepted on the edge where it has been seen DB_CYCLES times in a row.
  assign accept = (sync != stable) && (cnt == CNT_LAST);

  // Debounce counter and stable level; any return to the stable level restarts the count.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync == stable) begin
      cnt <= '0;
    end else if (accept) begin
      stable <= sync;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Rise is combinational so pend sets on the same edge that stable goes high.
  assign rise  = accept & sync;
  assign level = stable;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions five raw push-buttons into spaced, single-cycle press pulses.
// Presses latch into pend; a fixed-priority arbiter serves one per grant and
// then holds off for GAP_CYCLES idle cycles.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DB_CYCLES  = 500000,
  parameter int GAP_CYCLES = 2
) (
  input  logic               Clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic               BtnC,
  output logic               BtnU,
  output logic               BtnD,
  output logic               BtnR,
  output logic               BtnL,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] pend
);

  localparam int            GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);

  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] grant;
  logic [NUM_BTN-1:0] pulse;
  logic [GW-1:0]      gap;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .Clk     (Clk),
      .reset_n (reset_n),
      .raw     (btn_raw[i]),
      .level   (btn_level[i]),
      .rise    (rise[i])
    );
  end

  // Grant the highest-priority pending press once the gap has expired.
  always_comb begin
    grant = '0;
    if (gap == '0) begin
      grant = pick_prio(pend);
    end
  end

  // Pending bits, gap timer and pulse register. A press arriving on the same
  // edge its bit is served wins, so that press is kept for a later grant.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      pend  <= '0;
      gap   <= '0;
      pulse <= '0;
    end else begin
      pend  <= (pend & ~grant) | rise;
      pulse <= grant;
      if (grant != '0) begin
        gap <= GAP_LOAD;
      end else if (gap != '0) begin
        gap <= gap - 1'b1;
      end
    end
  end

  assign BtnC = pulse[BTN_C];
  assign BtnU = pulse[BTN_U];
  assign BtnD = pulse[BTN_D];
  assign BtnR = pulse[BTN_R];
  assign BtnL = pulse[BTN_L];

endmodule
